// File: rtl/note_lane_pool.sv
// note_lane_pool: pool of falling-note slots with a spawn handshake, per-frame advance, key judgement and score/combo.
// Define NOTE_LANE_POOL_COMBO_EN to keep a combo register and scale hit points by the current combo.
module note_lane_pool #(
  parameter int N_SLOTS  = 4,
  parameter int N_LANES  = 4,
  parameter int LANE_W   = 160,
  parameter int NOTE_H   = 32,
  parameter int SPEED    = 2,
  parameter int HIT_LINE = 450,
  parameter int HIT_WIN  = 16,
  parameter int SCORE_W  = 16,
  localparam int LIW     = (N_LANES > 1) ? $clog2(N_LANES) : 1,
  localparam int SIW     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               CLOCK_25,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               spawn_valid,
  input  logic [LIW-1:0]     spawn_lane,
  output logic               spawn_ready,
  input  logic [N_LANES-1:0] keys,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  output logic [N_LANES-1:0] sprite_lane,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int WIN_LO = HIT_LINE - HIT_WIN;
  localparam int WIN_HI = HIT_LINE + HIT_WIN;

  logic [N_SLOTS-1:0] r_active;
  logic [LIW-1:0]     r_lane [N_SLOTS];
  logic [9:0]         r_y [N_SLOTS];
  logic               r_ready;
  logic [SCORE_W-1:0] r_score;
  logic               r_hit;
  logic               r_miss;
  logic [N_LANES-1:0] r_key_p0;
  logic [N_LANES-1:0] r_key_p1;
  logic [N_LANES-1:0] r_key_p2;

  logic [N_LANES-1:0] w_press;
  logic [N_LANES-1:0] w_found;
  logic [SIW-1:0]     w_best [N_LANES];
  logic [9:0]         w_best_y [N_LANES];
  logic [N_SLOTS-1:0] w_hit_slot;
  logic [3:0]         w_h;
  logic               w_stray;
  logic               w_tick_miss;
  logic               w_m;
  logic [N_SLOTS-1:0] w_act_n;
  logic [9:0]         w_y_n [N_SLOTS];
  logic [LIW-1:0]     w_lane_n [N_SLOTS];
  logic               w_free_any;
  logic [SIW-1:0]     w_free_idx;
  logic [6:0]         w_points;
  logic [SCORE_W-1:0] w_score_n;
  logic [N_LANES-1:0] w_sprite;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] a, input logic [6:0] b);
    logic [SCORE_W+7:0] s;
    s = (SCORE_W+8)'(a) + (SCORE_W+8)'(b);
    if (s > (SCORE_W+8)'({SCORE_W{1'b1}})) return {SCORE_W{1'b1}};
    return s[SCORE_W-1:0];
  endfunction

`ifdef NOTE_LANE_POOL_COMBO_EN
  logic [7:0] r_combo;
  logic [7:0] w_combo_n;

  function automatic logic [7:0] sat_combo(input logic [7:0] c, input logic [3:0] h);
    logic [8:0] s;
    s = {1'b0, c} + 9'(h);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Multiplier grows by one every 8 combo, capped at 4.
  function automatic logic [2:0] combo_mult(input logic [7:0] c);
    logic [4:0] q;
    q = c[7:3];
    return (q > 5'd3) ? 3'd4 : (3'(q) + 3'd1);
  endfunction
`endif

  // Key synchroniser (p0, p1) and edge-detect history (p2)
  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_key_p0 <= '0;
      r_key_p1 <= '0;
      r_key_p2 <= '0;
    end else begin
      r_key_p0 <= keys;
      r_key_p1 <= r_key_p0;
      r_key_p2 <= r_key_p1;
    end
  end

  // Judgement: per lane, deepest in-window note wins, lowest index on a tie
  always_comb begin
    w_press    = r_key_p1 & ~r_key_p2;
    w_found    = '0;
    w_hit_slot = '0;
    w_h        = '0;
    w_stray    = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      w_best[l]   = '0;
      w_best_y[l] = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (r_active[i] && (r_lane[i] == LIW'(l)) &&
            (int'(r_y[i]) >= WIN_LO) && (int'(r_y[i]) <= WIN_HI) &&
            (!w_found[l] || (r_y[i] > w_best_y[l]))) begin
          w_found[l]  = 1'b1;
          w_best[l]   = SIW'(i);
          w_best_y[l] = r_y[i];
        end
      end
      if (w_press[l]) begin
        if (w_found[l]) begin
          w_hit_slot[w_best[l]] = 1'b1;
          w_h = w_h + 4'd1;
        end else begin
          w_stray = 1'b1;
        end
      end
    end
  end

  // Slot update: hits free first, then frame advance, then spawn into a slot idle before this edge
  always_comb begin
    logic [10:0] y_adv;
    y_adv       = '0;
    w_act_n     = r_active;
    w_tick_miss = 1'b0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_y_n[i]    = r_y[i];
      w_lane_n[i] = r_lane[i];
      if (w_hit_slot[i]) begin
        w_act_n[i] = 1'b0;
      end else if (r_active[i] && frame_tick) begin
        y_adv = {1'b0, r_y[i]} + 11'(SPEED);
        if (int'(y_adv) > WIN_HI) begin
          w_act_n[i]  = 1'b0;
          w_tick_miss = 1'b1;
        end else begin
          w_y_n[i] = y_adv[9:0];
        end
      end
    end
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SIW'(i);
      end
    end
    if (spawn_valid && r_ready && w_free_any) begin
      w_act_n[w_free_idx]  = 1'b1;
      w_y_n[w_free_idx]    = '0;
      w_lane_n[w_free_idx] = spawn_lane;
    end
  end

  assign w_m = w_stray | w_tick_miss;

`ifdef NOTE_LANE_POOL_COMBO_EN
  always_comb begin
    w_points  = 7'(w_h) * 7'(combo_mult(r_combo));
    w_combo_n = w_m ? 8'd0 : sat_combo(r_combo, w_h);
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) r_combo <= '0;
    else        r_combo <= w_combo_n;
  end

  assign combo = r_combo;
`else
  assign w_points = 7'(w_h);
  assign combo    = '0;
`endif

  assign w_score_n = sat_score(r_score, w_points);

  // Registered slot, score and event state
  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_lane[i] <= '0;
        r_y[i]    <= '0;
      end
      r_ready <= 1'b0;
      r_score <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_active <= w_act_n;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_lane[i] <= w_lane_n[i];
        r_y[i]    <= w_y_n[i];
      end
      r_ready <= ~&w_act_n;
      r_score <= w_score_n;
      r_hit   <= (w_h != 4'd0);
      r_miss  <= w_m;
    end
  end

  // Sprite lookup straight from registered slot state
  always_comb begin
    w_sprite = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (r_active[i] &&
          (int'(next_x) >= int'(r_lane[i]) * LANE_W) &&
          (int'(next_x) < (int'(r_lane[i]) + 1) * LANE_W) &&
          (next_y >= r_y[i]) &&
          ({1'b0, next_y} < ({1'b0, r_y[i]} + 11'(NOTE_H)))) begin
        w_sprite[r_lane[i]] = 1'b1;
      end
    end
  end

  assign spawn_ready = r_ready;
  assign sprite_lane = w_sprite;
  assign score       = r_score;
  assign hit_pulse   = r_hit;
  assign miss_pulse  = r_miss;

endmodule

// File: tb/tb_note_lane_pool.sv
// Bench for note_lane_pool: directed scenarios plus randomized traffic against a note-list reference model.
module tb_note_lane_pool;

  localparam int N_SLOTS   = 4;
  localparam int N_LANES   = 4;
  localparam int LANE_W    = 160;
  localparam int NOTE_H    = 32;
  localparam int SPEED     = 2;
  localparam int HIT_LINE  = 450;
  localparam int HIT_WIN   = 16;
  localparam int SCORE_W   = 16;
  localparam int WIN_LO    = HIT_LINE - HIT_WIN;
  localparam int WIN_HI    = HIT_LINE + HIT_WIN;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
`ifdef NOTE_LANE_POOL_COMBO_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               spawn_valid = 1'b0;
  logic [1:0]         spawn_lane = '0;
  logic               spawn_ready;
  logic [N_LANES-1:0] keys = '0;
  logic [9:0]         next_x = '0;
  logic [9:0]         next_y = '0;
  logic [N_LANES-1:0] sprite_lane;
  logic [SCORE_W-1:0] score;
  logic [7:0]         combo;
  logic               hit_pulse;
  logic               miss_pulse;

  note_lane_pool dut (
    .CLOCK_25    (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .keys        (keys),
    .next_x      (next_x),
    .next_y      (next_y),
    .sprite_lane (sprite_lane),
    .score       (score),
    .combo       (combo),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a list of notes plus the key samples seen at past edges
  bit               m_act [N_SLOTS];
  int               m_lane [N_SLOTS];
  int               m_y [N_SLOTS];
  int               m_score;
  int               m_combo;
  bit               m_hit;
  bit               m_miss;
  bit               m_ready;
  bit [N_LANES-1:0] kd1, kd2, kd3;

  function automatic void model_reset();
    for (int i = 0; i < N_SLOTS; i++) begin
      m_act[i] = 0; m_lane[i] = 0; m_y[i] = 0;
    end
    m_score = 0; m_combo = 0; m_hit = 0; m_miss = 0; m_ready = 0;
    kd1 = '0; kd2 = '0; kd3 = '0;
  endfunction

  function automatic void model_edge(input bit tick, input bit sv, input int sl, input bit [N_LANES-1:0] k);
    bit [N_LANES-1:0] press;
    bit was_act [N_SLOTS];
    bit hit [N_SLOTS];
    bit placed;
    int h, m, best, mult;
    // A key first sampled high two edges ago, low three edges ago, is a press judged now
    press = kd2 & ~kd3;
    kd3 = kd2; kd2 = kd1; kd1 = k;
    h = 0; m = 0;
    for (int i = 0; i < N_SLOTS; i++) begin
      was_act[i] = m_act[i];
      hit[i] = 0;
    end
    for (int l = 0; l < N_LANES; l++) begin
      if (press[l]) begin
        best = -1;
        for (int i = 0; i < N_SLOTS; i++) begin
          if (m_act[i] && m_lane[i] == l && m_y[i] >= WIN_LO && m_y[i] <= WIN_HI) begin
            if (best < 0) best = i;
            else if (m_y[i] > m_y[best]) best = i;
          end
        end
        if (best >= 0) begin
          hit[best] = 1;
          h++;
        end else begin
          m++;
        end
      end
    end
    for (int i = 0; i < N_SLOTS; i++) begin
      if (hit[i]) begin
        m_act[i] = 0;
      end else if (m_act[i] && tick) begin
        m_y[i] = m_y[i] + SPEED;
        if (m_y[i] > WIN_HI) begin
          m_act[i] = 0;
          m++;
        end
      end
    end
    placed = 0;
    if (sv && m_ready) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (!was_act[i] && !placed) begin
          m_act[i] = 1; m_lane[i] = sl; m_y[i] = 0; placed = 1;
        end
      end
    end
    mult = 1;
    if (COMBO_EN) mult = 1 + (((m_combo / 8) > 3) ? 3 : (m_combo / 8));
    m_score = m_score + h * mult;
    if (m_score > SCORE_MAX) m_score = SCORE_MAX;
    if (!COMBO_EN || m > 0) m_combo = 0;
    else m_combo = (m_combo + h > 255) ? 255 : m_combo + h;
    m_hit = (h > 0);
    m_miss = (m > 0);
    m_ready = 0;
    for (int i = 0; i < N_SLOTS; i++) if (!m_act[i]) m_ready = 1;
  endfunction

  function automatic bit [N_LANES-1:0] exp_sprite(input int x, input int y);
    bit [N_LANES-1:0] r;
    r = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (m_act[i] && (x / LANE_W) == m_lane[i] && y >= m_y[i] && y < m_y[i] + NOTE_H)
        r[m_lane[i]] = 1'b1;
    return r;
  endfunction

  task automatic do_cycle(input bit tick, input bit sv, input int sl, input bit [N_LANES-1:0] k);
    frame_tick  = tick;
    spawn_valid = sv;
    spawn_lane  = sl[1:0];
    keys        = k;
    @(posedge clk);
    model_edge(tick, sv, sl, k);
    #1;
  endtask

  task automatic do_reset();
    frame_tick = 0; spawn_valid = 0; spawn_lane = '0; keys = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) do_cycle(1'b1, 1'b0, 0, '0);
  endtask

  // Hold a key two cycles, then release; judgement lands on the third edge
  task automatic press(input int lane, input bit tick_on_judge);
    bit [N_LANES-1:0] k;
    k = '0;
    k[lane] = 1'b1;
    do_cycle(1'b0, 1'b0, 0, k);
    do_cycle(1'b0, 1'b0, 0, k);
    do_cycle(tick_on_judge, 1'b0, 0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    next_x = 10'd330; next_y = 10'd5; #1;
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", spawn_ready); end
    checks++; if (score !== '0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo got %0d want 0", combo); end
    checks++; if ({hit_pulse, miss_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {hit_pulse, miss_pulse}); end
    checks++; if (sprite_lane !== 4'b0000) begin errors++; $display("FAIL reset_sprite got %b want 0000", sprite_lane); end
    do_cycle(1'b0, 1'b0, 0, '0);
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", spawn_ready); end
  endtask

  task automatic test_spawn_fill();
    do_reset();
    do_cycle(1'b0, 1'b0, 0, '0);
    do_cycle(1'b0, 1'b1, 2, '0);
    next_x = 10'd327; next_y = 10'd3; #1;
    checks++; if (sprite_lane !== 4'b0100) begin errors++; $display("FAIL spawn_sprite got %b want 0100", sprite_lane); end
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL spawn_ready1 got %b want 1", spawn_ready); end
    repeat (3) do_cycle(1'b0, 1'b1, 2, '0);
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("FAIL spawn_full got %b want 0", spawn_ready); end
    do_cycle(1'b0, 1'b1, 2, '0);
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("FAIL spawn_wait got %b want 0", spawn_ready); end
    spawn_valid = 1'b0;
  endtask

  task automatic test_hit();
    do_reset();
    do_cycle(1'b0, 1'b0, 0, '0);
    do_cycle(1'b0, 1'b1, 1, '0);
    run_ticks(225);
    next_x = 10'd165; next_y = 10'd460; #1;
    checks++; if (sprite_lane !== 4'b0010) begin errors++; $display("FAIL hit_pre_sprite got %b want 0010", sprite_lane); end
    do_cycle(1'b0, 1'b0, 0, 4'b0010);
    do_cycle(1'b0, 1'b0, 0, 4'b0010);
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_early got %b want 0", hit_pulse); end
    do_cycle(1'b0, 1'b0, 0, 4'b0000);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse got %b want 1", hit_pulse); end
    checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL hit_nomiss got %b want 0", miss_pulse); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL hit_score got %0d want 1", score); end
    checks++; if (combo !== (COMBO_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL hit_combo got %0d want %0d", combo, COMBO_EN ? 1 : 0); end
    checks++; if (sprite_lane !== 4'b0000) begin errors++; $display("FAIL hit_freed got %b want 0000", sprite_lane); end
    do_cycle(1'b0, 1'b0, 0, '0);
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_oneshot got %b want 0", hit_pulse); end
  endtask

  task automatic test_stray();
    press(0, 1'b0);
    checks++; if (miss_pulse !== 1'b1) begin errors++; $display("FAIL stray_miss got %b want 1", miss_pulse); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL stray_hit got %b want 0", hit_pulse); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL stray_score got %0d want 1", score); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL stray_combo got %0d want 0", combo); end
  endtask

  task automatic test_miss();
    do_reset();
    do_cycle(1'b0, 1'b0, 0, '0);
    do_cycle(1'b0, 1'b1, 3, '0);
    run_ticks(233);
    next_x = 10'd481; next_y = 10'd470; #1;
    checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_edge466 got %b want 0", miss_pulse); end
    checks++; if (sprite_lane !== 4'b1000) begin errors++; $display("FAIL miss_sprite466 got %b want 1000", sprite_lane); end
    run_ticks(1);
    checks++; if (miss_pulse !== 1'b1) begin errors++; $display("FAIL miss_pulse got %b want 1", miss_pulse); end
    checks++; if (sprite_lane !== 4'b0000) begin errors++; $display("FAIL miss_freed got %b want 0000", sprite_lane); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL miss_combo got %0d want 0", combo); end
    do_cycle(1'b0, 1'b0, 0, '0);
    checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_oneshot got %b want 0", miss_pulse); end
  endtask

  task automatic test_priority();
    do_reset();
    do_cycle(1'b0, 1'b0, 0, '0);
    do_cycle(1'b0, 1'b1, 3, '0);
    run_ticks(10);
    do_cycle(1'b0, 1'b1, 3, '0);
    run_ticks(220);
    next_x = 10'd481; next_y = 10'd480; #1;
    checks++; if (sprite_lane !== 4'b1000) begin errors++; $display("FAIL prio_deep_present got %b want 1000", sprite_lane); end
    press(3, 1'b0);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL prio_hit got %b want 1", hit_pulse); end
    checks++; if (sprite_lane !== 4'b0000) begin errors++; $display("FAIL prio_deep_gone got %b want 0000", sprite_lane); end
    next_y = 10'd445; #1;
    checks++; if (sprite_lane !== 4'b1000) begin errors++; $display("FAIL prio_shallow_kept got %b want 1000", sprite_lane); end
    press(3, 1'b1);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL prio_tick_hit got %b want 1", hit_pulse); end
    checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL prio_tick_nomiss got %b want 0", miss_pulse); end
    checks++; if (sprite_lane !== 4'b0000) begin errors++; $display("FAIL prio_tick_freed got %b want 0000", sprite_lane); end
    checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL prio_score got %0d want %0d", score, m_score); end
  endtask

  task automatic test_combo16();
    do_reset();
    do_cycle(1'b0, 1'b0, 0, '0);
    for (int r = 0; r < 16; r++) begin
      do_cycle(1'b0, 1'b1, r % 4, '0);
      run_ticks(225);
      press(r % 4, 1'b0);
    end
    checks++; if (score !== (COMBO_EN ? 16'd24 : 16'd16)) begin errors++; $display("FAIL combo16_score got %0d want %0d", score, COMBO_EN ? 24 : 16); end
    checks++; if (combo !== (COMBO_EN ? 8'd16 : 8'd0)) begin errors++; $display("FAIL combo16_combo got %0d want %0d", combo, COMBO_EN ? 16 : 0); end
  endtask

  task automatic test_random();
    bit [N_LANES-1:0] k;
    int j;
    k = '0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spawn_ready, hit_pulse, miss_pulse, score, combo} !== '0) begin
          errors++;
          $display("FAIL rnd_async_reset got ready=%b hit=%b miss=%b score=%0d combo=%0d want all 0",
                   spawn_ready, hit_pulse, miss_pulse, score, combo);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      for (int l = 0; l < N_LANES; l++) if ($urandom_range(0, 7) == 0) k[l] = ~k[l];
      do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), k);
      next_x = 10'($urandom_range(0, 639));
      j = int'($urandom_range(0, N_SLOTS - 1));
      if (m_act[j]) begin
        next_x = 10'(m_lane[j] * LANE_W + int'($urandom_range(0, LANE_W - 1)));
        next_y = 10'(((m_y[j] + int'($urandom_range(0, 40)) - 4) < 0) ? 0 : (m_y[j] + int'($urandom_range(0, 40)) - 4));
      end else begin
        next_y = 10'($urandom_range(0, 479));
      end
      #1;
      checks++; if (spawn_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, spawn_ready, m_ready); end
      checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL rnd_score cyc %0d got %0d want %0d", c, score, m_score); end
      checks++; if (combo !== 8'(m_combo)) begin errors++; $display("FAIL rnd_combo cyc %0d got %0d want %0d", c, combo, m_combo); end
      checks++; if (hit_pulse !== m_hit) begin errors++; $display("FAIL rnd_hit cyc %0d got %b want %b", c, hit_pulse, m_hit); end
      checks++; if (miss_pulse !== m_miss) begin errors++; $display("FAIL rnd_miss cyc %0d got %b want %b", c, miss_pulse, m_miss); end
      checks++;
      if (sprite_lane !== exp_sprite(int'(next_x), int'(next_y))) begin
        errors++;
        $display("FAIL rnd_sprite cyc %0d x=%0d y=%0d got %b want %b", c, next_x, next_y,
                 sprite_lane, exp_sprite(int'(next_x), int'(next_y)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn_fill();
    test_hit();
    test_stray();
    test_miss();
    test_priority();
    test_combo16();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
